// File: rtl/uart_tx_framer.sv
// uart_tx_framer: frames words popped from a first-word-fall-through FIFO into
// a UART line: start (0), NBITS data LSB first, even parity, stop (1).
//
// Ports
//   clk      : single clock, rising edge
//   reset    : synchronous active-high reset
//   tx_empty : source FIFO empty flag
//   tx_data  : FIFO head word, valid while tx_empty=0
//   tx_rd    : one-cycle FIFO pop strobe, high only in LOAD
//   tx       : registered serial line, idle high
//   tx_busy  : high in every state except IDLE
//   tx_done  : one-cycle pulse after each completed frame
//   frame    : parallel copy of the last frame launched
module uart_tx_framer #(
  parameter int unsigned NBITS        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_empty,
  input  logic [NBITS-1:0]   tx_data,
  output logic               tx_rd,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [NBITS+2:0]   frame
);

  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned FRAME_W = NBITS + 3;
  localparam int unsigned PAR_POS = NBITS + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nx;
  logic [BAUD_W-1:0]    baud_cnt, baud_cnt_nx;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
  logic [NBITS-1:0]     shreg, shreg_nx;
  logic [FRAME_W-1:0]   frame_nx;
  logic                 tx_nx, tx_rd_nx, tx_busy_nx, tx_done_nx;
  logic                 baud_term_c;

  // Last cycle of the current serial bit
  assign baud_term_c = (baud_cnt == BAUD_LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      frame    <= '0;
      tx       <= 1'b1;
      tx_rd    <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shreg    <= shreg_nx;
      frame    <= frame_nx;
      tx       <= tx_nx;
      tx_rd    <= tx_rd_nx;
      tx_busy  <= tx_busy_nx;
      tx_done  <= tx_done_nx;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    frame_nx    = frame;
    tx_done_nx  = 1'b0;
    tx_nx       = 1'b1;
    tx_rd_nx    = 1'b0;
    tx_busy_nx  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!tx_empty) state_nx = S_LOAD;
      end
      S_LOAD: begin
        // The popped head word is captured here; later input changes are ignored
        shreg_nx = tx_data;
        frame_nx = {1'b1, ^tx_data, tx_data, 1'b0};
        state_nx = S_START;
      end
      S_START: begin
        if (baud_term_c) state_nx = S_DATA;
      end
      S_DATA: begin
        if (baud_term_c) begin
          if (bit_idx == IDX_LAST) begin
            state_nx = S_PARITY;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
            shreg_nx   = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_term_c) state_nx = S_STOP;
      end
      S_STOP: begin
        if (baud_term_c) begin
          tx_done_nx = 1'b1;
          state_nx   = tx_empty ? S_IDLE : S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Baud counter wraps at each bit boundary and restarts on every state entry
    if ((state_nx != state) || (state == S_IDLE) || (state == S_LOAD) || baud_term_c) begin
      baud_cnt_nx = '0;
    end else begin
      baud_cnt_nx = baud_cnt + 1'b1;
    end

    if (state_nx != S_DATA) bit_idx_nx = '0;

    // Outputs are registered, so they are derived from the state being entered
    tx_rd_nx   = (state_nx == S_LOAD);
    tx_busy_nx = (state_nx != S_IDLE);
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shreg_nx[0];
      S_PARITY: tx_nx = frame_nx[PAR_POS];
      default:  tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer (NBITS=8, CLKS_PER_BIT=16): a FWFT FIFO model
// feeds the DUT, a timeline model predicts every output each cycle, and
// directed scenarios pin frame values, line bits, gaps and latencies.
module tb_uart_tx_framer;

  localparam int NB        = 8;
  localparam int CPB       = 16;
  localparam int NFB       = NB + 3;
  localparam int FRAME_CYC = NFB * CPB;

  logic           clk = 1'b0;
  logic           reset;
  logic           tx_empty;
  logic [NB-1:0]  tx_data;
  logic           tx_rd, tx, tx_busy, tx_done;
  logic [NB+2:0]  frame;

  int checks   = 0;
  int failures = 0;

  uart_tx_framer #(.NBITS(NB), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_empty (tx_empty),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  // Frame built from the layout rules: start, data LSB first, even parity, stop
  function automatic logic [NFB-1:0] make_frame(input logic [NB-1:0] d);
    logic [NFB-1:0] f;
    int ones;
    f    = '0;
    ones = 0;
    for (int i = 0; i < NB; i++) begin
      f[1+i] = d[i];
      ones   = ones + int'(d[i]);
    end
    f[NB+1] = ((ones % 2) == 1);
    f[NB+2] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Timeline model: cycles elapsed since the LOAD cycle of the current frame
  logic           m_valid  = 1'b0;
  logic           m_active = 1'b0;
  int             m_cyc    = 0;
  logic           m_done   = 1'b0;
  logic [NFB-1:0] m_frame  = '0;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_done   = 1'b0;
      m_frame  = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_cyc++;
        if (m_cyc == 1) m_frame = make_frame(tx_data);
        if (m_cyc == FRAME_CYC + 1) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
      if (!m_active && !tx_empty) begin
        m_active = 1'b1;
        m_cyc    = 0;
      end
    end
  end

  // Monitor state shared with the directed scenarios
  int             cyc         = 0;
  int             n_rd        = 0;
  int             n_done      = 0;
  int             last_rd_cyc = -100;
  int             last_done_cyc = -100;
  int             start_cyc   = -100000;
  int             hi_run      = 0;
  int             busy_falls  = 0;
  logic           prev_busy   = 1'b0;
  logic           rd_seen     = 1'b0;
  logic [NFB-1:0] cap         = '0;
  int             gaps[$];

  // Per-cycle compare against the model, plus line bookkeeping
  always @(negedge clk) begin
    logic [NFB+3:0] act, exp;
    logic           e_tx;
    int             off;
    cyc++;
    if (m_valid) begin
      e_tx = (m_active && m_cyc >= 1) ? m_frame[(m_cyc - 1) / CPB] : 1'b1;
      exp  = {e_tx, (m_active && m_cyc == 0), m_active, m_done, m_frame};
      act  = {tx, tx_rd, tx_busy, tx_done, frame};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL cycle %0d outputs: got tx=%b rd=%b busy=%b done=%b frame=%h, expected tx=%b rd=%b busy=%b done=%b frame=%h",
                 cyc, tx, tx_rd, tx_busy, tx_done, frame,
                 exp[NFB+3], exp[NFB+2], exp[NFB+1], exp[NFB], exp[NFB-1:0]);
      end
    end
    rd_seen = tx_rd;
    if (tx_rd === 1'b1) begin
      n_rd++;
      last_rd_cyc = cyc;
    end
    if (tx_done === 1'b1) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (cyc == last_rd_cyc + 1) begin
      start_cyc = cyc;
      gaps.push_back(hi_run);
    end
    off = cyc - start_cyc;
    if (off >= 0 && (off % CPB) == CPB / 2 && (off / CPB) < NFB) cap[off / CPB] = tx;
    hi_run = (tx === 1'b1) ? hi_run + 1 : 0;
    if (prev_busy === 1'b1 && tx_busy === 1'b0) busy_falls++;
    prev_busy = tx_busy;
  end

  // FWFT FIFO feeding the DUT
  logic [NB-1:0] q[$];

  task automatic refresh();
    tx_empty = (q.size() == 0);
    tx_data  = tx_empty ? NB'($urandom) : q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_seen && q.size() > 0) q.delete(0);
    refresh();
  endtask

  task automatic push(input logic [NB-1:0] w);
    q.push_back(w);
    refresh();
  endtask

  task automatic wait_done(input int target, input string name);
    int budget;
    budget = 2000;
    while (n_done < target && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_done_seen"}, 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_rd(input int target, input string name);
    int budget;
    budget = 2000;
    while (n_rd < target && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_rd_seen"}, 32'(n_rd >= target), 32'd1);
  endtask

  initial begin
    int rd0, done0, bf0, g0;
    reset = 1'b1;
    q.delete();
    refresh();

    // Reset held while the FIFO is non-empty
    push(8'hAA);
    repeat (6) begin
      tick();
      check("reset_hold", {28'd0, tx, tx_rd, tx_busy, (frame != '0)}, {28'd0, 4'b1000});
    end

    // First edge after release evaluates tx_empty
    reset = 1'b0;
    tick();
    check("first_edge_load", 32'(tx_rd), 32'd1);

    // Single word 0xAA
    wait_done(1, "aa");
    check("aa_frame", 32'(frame), 32'h554);
    check("aa_line", 32'(cap), 32'h554);
    check("aa_rd_count", 32'(n_rd), 32'd1);
    check("aa_done_latency", 32'(last_done_cyc - start_cyc), 32'd176);

    // Odd weight word sets the parity bit
    repeat (3) tick();
    push(8'h83);
    wait_done(2, "x83");
    check("x83_frame", 32'(frame), 32'h706);
    check("x83_parity", 32'(frame[NB+1]), 32'd1);
    check("x83_line", 32'(cap), 32'h706);

    // Back-to-back burst of three words
    repeat (5) tick();
    rd0 = n_rd; done0 = n_done; bf0 = busy_falls; g0 = gaps.size();
    push(8'hAA);
    push(8'h82);
    push(8'hE2);
    wait_done(done0 + 3, "burst");
    repeat (3) tick();
    check("burst_rd", 32'(n_rd - rd0), 32'd3);
    check("burst_done", 32'(n_done - done0), 32'd3);
    check("burst_busy_falls", 32'(busy_falls - bf0), 32'd1);
    check("burst_gap_count", 32'(gaps.size() - g0), 32'd3);
    check("burst_gap1", 32'(gaps[g0 + 1]), 32'd17);
    check("burst_gap2", 32'(gaps[g0 + 2]), 32'd17);
    check("burst_frame", 32'(frame), 32'h5C4);
    check("burst_line", 32'(cap), 32'h5C4);

    // Head word changes while a frame is in flight
    done0 = n_done;
    push(8'h0F);
    push(8'hF0);
    wait_done(done0 + 1, "hold1");
    check("hold_line1", 32'(cap), 32'h41E);
    wait_done(done0 + 2, "hold2");
    check("hold_line2", 32'(cap), 32'h5E0);
    check("hold_frame2", 32'(frame), 32'h5E0);

    // Reset pulsed during data bit 3 aborts the frame
    repeat (4) tick();
    rd0 = n_rd; done0 = n_done;
    push(8'h52);
    push(8'h3C);
    wait_rd(rd0 + 1, "abort");
    tick();                      // LOAD closing edge, now first START cycle
    repeat (64 + 5) tick();      // into data bit 3
    check("abort_bit3_low", {30'd0, tx, tx_busy}, {30'd0, 2'b01});
    reset = 1'b1;
    tick();
    check("abort_after_reset", {28'd0, tx, tx_busy, tx_done, (frame != '0)}, {28'd0, 4'b1000});
    reset = 1'b0;
    wait_done(done0 + 1, "restart");
    check("restart_frame", 32'(frame), 32'h478);
    check("restart_line", 32'(cap), 32'h478);
    check("restart_rd", 32'(n_rd - rd0), 32'd2);
    check("restart_done", 32'(n_done - done0), 32'd1);

    repeat (20) tick();
    check("final_idle", {30'd0, tx, tx_busy}, {30'd0, 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
